// File: rtl/div_unit.sv
// Iterative restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Latency: XLEN+2 cycles from accepted start to done; 1 cycle for divide-by-zero/overflow.
// Backpressure: busy stalls the pipe; start while busy is ignored, start during done is accepted.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] dvs;
    logic            rem_sel;
    logic            qneg;
    logic            rneg;

    logic            signed_op;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic            div_zero;
    logic            ovf;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] fix_sel;
    logic            fix_neg;

    assign signed_op = ~op[0];
    assign a_abs     = (signed_op && a[XLEN-1]) ? -a : a;
    assign b_abs     = (signed_op && b[XLEN-1]) ? -b : b;
    assign div_zero  = (b == '0);
    assign ovf       = signed_op && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

    // Extra bit: an unsigned divisor near 2^XLEN needs the shifted remainder's carry-out.
    assign trial     = {rem, quo[XLEN-1]} - {1'b0, dvs};
    assign fix_sel   = rem_sel ? rem : quo;
    assign fix_neg   = rem_sel ? rneg : qneg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            rem_sel <= 1'b0;
            qneg    <= 1'b0;
            rneg    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        rem_sel <= op[1];
                        if (div_zero) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= op[1] ? a : '1;
                        end else if (ovf) begin
                            // Overflow quotient equals the dividend (most negative value).
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= op[1] ? '0 : a;
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                            cnt   <= '0;
                            rem   <= '0;
                            quo   <= a_abs;
                            dvs   <= b_abs;
                            qneg  <= signed_op & (a[XLEN-1] ^ b[XLEN-1]);
                            rneg  <= signed_op & a[XLEN-1];
                        end
                    end
                end
                CALC: begin
                    if (trial[XLEN])
                        rem <= {rem[XLEN-2:0], quo[XLEN-1]};
                    else
                        rem <= trial[XLEN-1:0];
                    quo <= {quo[XLEN-2:0], ~trial[XLEN]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(XLEN-1))
                        state <= FIX;
                end
                FIX: begin
                    result <= fix_neg ? -fix_sel : fix_sel;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, special cases, start gating, reset abort.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    div_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op, then count cycles (cycle c = period after edge c) until done.
    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp, input int ecyc);
        int cyc;
        int nbusy;
        cyc   = 0;
        nbusy = 0;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                cyc = c;
                break;
            end
            if (busy) nbusy++;
        end
        chk({tag, " done cycle"}, cyc, ecyc);
        if (cyc != 0) begin
            chk({tag, " result"}, result, exp);
            chk({tag, " busy in done"}, 32'(busy), 32'd0);
            chk({tag, " busy cycles"}, nbusy, (ecyc == 1) ? 0 : ecyc - 1);
        end
        @(negedge clk);
        chk({tag, " done width"}, 32'(done), 32'd0);
    endtask

    initial begin
        int c1;
        int c2;
        int seen;

        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", result, 32'd0);
        rst = 1'b0;

        run("divu 100/7",  OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
        run("remu 100/7",  OP_REMU, 32'd100, 32'd7, 32'd2,  34);
        run("div -7/2",    OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run("rem -7/2",    OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run("div 7/-2",    OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
        run("rem 7/-2",    OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 34);
        run("divu x/0",    OP_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1);
        run("rem x/0",     OP_REM,  32'h1234_5678, 32'd0, 32'h1234_5678, 1);
        run("div ovf",     OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run("rem ovf",     OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run("divu no-ovf", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);
        run("divu big",    OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 34);
        run("remu big",    OP_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 34);
        run("remu 16",     OP_REMU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 34);

        // Start while busy is ignored; start held in the done cycle is accepted.
        c1 = 0;
        @(negedge clk);
        op = OP_DIVU; a = 32'd1000; b = 32'd10; start = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 9) begin a = 32'd5; b = 32'd1; start = 1'b1; end
            if (c == 10) start = 1'b0;
            if (done) begin
                c1 = c;
                break;
            end
        end
        chk("b2b first cycle", c1, 34);
        chk("b2b first result", result, 32'd100);
        op = OP_DIVU; a = 32'd77; b = 32'd7; start = 1'b1;
        c2 = 0;
        for (int c = c1 + 1; c <= 120; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == c1 + 1) chk("b2b accepted busy", 32'(busy), 32'd1);
            if (done) begin
                c2 = c;
                break;
            end
        end
        chk("b2b second cycle", c2, 68);
        chk("b2b second result", result, 32'd11);
        @(negedge clk);

        // Reset mid-operation aborts without a done pulse.
        @(negedge clk);
        op = OP_DIV; a = 32'hFFFF_FF9C; b = 32'd3; start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre-abort busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort no done", seen, 0);
        run("divu 9/3", OP_DIVU, 32'd9, 32'd3, 32'd3, 34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative multi-cycle integer divider for the core's execute stage, implementing the four RISC-V M-extension divide ops (DIV, DIVU, REM, REMU). It sits directly upstream of the writeback-select 32-bit multiplexer. Its `result` drives that mux's alternate data input, and its `done` pulse, qualified by the decoder, drives the mux selector. The unit accepts one operation at a time, stalls the pipeline via `busy`, and holds its result until the next accepted start.

## Interface
- `XLEN`, default 32: operand/result width; iteration count equals `XLEN`.

- `clk`, in, 1: single clock; all state updates on rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: request; sampled on a rising edge only while `busy`=0.
- `op`, in, 2: 00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU.
- `a`, in, XLEN: dividend; sampled with `start`.
- `b`, in, XLEN: divisor; sampled with `start`.
- `busy`, out, 1: high while an operation is in flight (states CALC, FIX).
- `done`, out, 1: single-cycle pulse; `result` is valid in that cycle.
- `result`, out, XLEN: quotient or remainder; held stable from `done` until the next accepted start completes.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE or DONE with `start`=1 latches `op`, `a`, `b` and classifies the request:
  - `b`=0: go to DONE with the special result.
  - Signed op with `a`=0x80000000 and `b`=0xFFFFFFFF (overflow): go to DONE with the special result.
  - Otherwise: go to CALC. Iteration counter=0. Remainder register=0. For signed ops, the quotient shift register is loaded with |a|; for unsigned ops, with `a`. The divisor is loaded with |b| for signed ops and `b` for unsigned ops. Negate flags are recorded: quotient sign = a[MSB]^b[MSB], remainder sign = a[MSB] (signed ops only).
- CALC performs one restoring step per cycle:
  - Shift {rem,quo} left by 1.
  - Trial-subtract the divisor from rem using an XLEN+1-bit subtract.
  - If non-negative, rem takes the difference and quo LSB=1; otherwise quo LSB=0.
  - After `XLEN` steps, go to FIX.
- FIX selects quo or rem per `op`, applies two's-complement negation if the corresponding sign flag is set, writes `result`, then goes to DONE.
- DONE asserts `done` for exactly one cycle. With no new `start` it returns to IDLE.
- Special results:
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give `a`.
  - Overflow: DIV gives 0x80000000; REM gives 0.
- Remainder sign always follows the dividend; quotient truncates toward zero.
- `start` while `busy`=1 is ignored, with no effect on state or latched operands.
- `start` in the DONE cycle is accepted; `done` still pulses that cycle for the previous op.
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, all internal registers 0.
- Reset asserted mid-operation aborts immediately. No `done` is produced for the aborted op.

## Timing
- Start accepted at edge 0.
- Normal path: `busy` is high in cycles 1..XLEN+1 (CALC for XLEN cycles, FIX for 1 cycle). `done` is high in cycle XLEN+2, which is cycle 34 for XLEN=32.
- Special path: `busy` stays 0 and `done` is high in cycle 1.
- Throughput: with back-to-back starts (start held high during DONE), the next `done` follows XLEN+2 cycles later.
- Outputs are purely registered; there is no combinational path from inputs to `busy`, `done` or `result`.

## Test plan
- DIVU a=100, b=7: `done` at cycle 34 with `result`=14. REMU same operands gives 2. `busy` is high exactly cycles 1..33.
- DIV a=-7 (0xFFFFFFF9), b=2 gives 0xFFFFFFFD (-3). REM same operands gives 0xFFFFFFFF (-1). DIV a=7, b=-2 gives 0xFFFFFFFD, and REM gives 1.
- DIVU a=0x12345678, b=0: `done` at cycle 1 with `result`=0xFFFFFFFF. REM with the same operands gives 0x12345678.
- DIV a=0x80000000, b=0xFFFFFFFF gives 0x80000000 at cycle 1. REM with the same operands gives 0. DIVU with the same operands takes the normal path and gives 0.
- Start DIVU 1000/10, then pulse `start` with a=5, b=1 at cycle 10. `result`=100 at cycle 34 and the second request is ignored. Assert `start` again during that `done` cycle and verify the second op completes at cycle 68.
- Assert `rst` at cycle 15 of a DIV op. `busy`, `done` and `result` read 0 immediately, with no `done` pulse afterwards. A fresh DIVU 9/3 then gives 3 at cycle 34.
